// File: rtl/irda_mir_rx_dpll.sv
// ---------------------------------------------------------------------------
// irda_mir_rx_dpll
//
// MIR (1.152 Mb/s) receive front end. Synchronizes the raw IR transceiver
// pulse input, recovers bit-cell timing with a digital phase-locked counter
// and turns pulse / no-pulse cells into the NRZ bit stream plus a per-bit
// strobe for the MIR receiver.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per bit cell (N), multiple of 4, 8..32
//   PH_W         : phase counter width, 2**PH_W >= CLKS_PER_BIT
//   IDLE_CELLS   : consecutive pulse-free cells before lock is dropped, 1..15
//
// Ports
//   clk              : system clock, N x bit rate
//   wb_rst_i         : asynchronous active-high reset
//   rx_pad_i         : raw IR receiver output (asynchronous, active-high)
//   mir_rx_en        : receive path enable, low holds the block idle
//   rx_o             : recovered bit, 0 = pulse in cell, held between strobes
//   mir_rxbit_enable : one-clk strobe per bit cell
//   mir_dpll_locked  : phase aligned to incoming pulses
//
// Build option
//   IRDA_MIR_RX_GLITCH_FILTER_EN : adds a third sync stage so that pad
//   pulses shorter than 2 clk are ignored (pad-to-rise latency 3 clk).
// ---------------------------------------------------------------------------
module irda_mir_rx_dpll #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PH_W         = 5,
  parameter int unsigned IDLE_CELLS   = 8
) (
  input  logic clk,
  input  logic wb_rst_i,
  input  logic rx_pad_i,
  input  logic mir_rx_en,
  output logic rx_o,
  output logic mir_rxbit_enable,
  output logic mir_dpll_locked
);

  localparam logic [PH_W-1:0] PH_T    = PH_W'(CLKS_PER_BIT / 4);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLKS_PER_BIT - 1);
  localparam logic [PH_W-1:0] PH_PEN  = PH_W'(CLKS_PER_BIT - 2);
  localparam logic [3:0]      IDLE_MAX = 4'(IDLE_CELLS);

  typedef enum logic {
    ST_UNLOCKED,
    ST_LOCKED
  } lock_state_e;

  // -------------------------------------------------------------------------
  // Pad synchronizer and rising-edge qualification
  // -------------------------------------------------------------------------
  logic r_sync1;
  logic r_s;
  logic r_s_d;
  logic w_rise;

`ifdef IRDA_MIR_RX_GLITCH_FILTER_EN
  logic r_s_d2;

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_sync1 <= 1'b0;
      r_s     <= 1'b0;
      r_s_d   <= 1'b0;
      r_s_d2  <= 1'b0;
    end else begin
      r_sync1 <= rx_pad_i;
      r_s     <= r_sync1;
      r_s_d   <= r_s;
      r_s_d2  <= r_s_d;
    end
  end

  // High for two consecutive samples after a low one.
  assign w_rise = r_s & r_s_d & ~r_s_d2;
`else
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_sync1 <= 1'b0;
      r_s     <= 1'b0;
      r_s_d   <= 1'b0;
    end else begin
      r_sync1 <= rx_pad_i;
      r_s     <= r_sync1;
      r_s_d   <= r_s;
    end
  end

  assign w_rise = r_s & ~r_s_d;
`endif

  // -------------------------------------------------------------------------
  // Lock state, phase counter, pulse flag and idle-cell counter
  // -------------------------------------------------------------------------
  lock_state_e     r_state;
  lock_state_e     w_state_nx;
  logic [PH_W-1:0] r_ph;
  logic [PH_W-1:0] w_ph_nx;
  logic            r_pf;
  logic            w_pf_nx;
  logic [3:0]      r_idle;
  logic [3:0]      w_idle_nx;
  logic            w_cell_end;
  logic            r_rx;
  logic            r_stb;

  // State register process.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= ST_UNLOCKED;
      r_ph    <= '0;
      r_pf    <= 1'b0;
      r_idle  <= '0;
      r_rx    <= 1'b1;
      r_stb   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_ph    <= w_ph_nx;
      r_pf    <= w_pf_nx;
      r_idle  <= w_idle_nx;
      r_stb   <= w_cell_end;
      if (!mir_rx_en) begin
        r_rx <= 1'b1;
      end else if (w_cell_end) begin
        r_rx <= ~w_pf_nx;
      end
    end
  end

  // Next-state process.
  // The cell-end bookkeeping is keyed on the phase being *entered* so that the
  // registered strobe and bit are presented during the ph = N-1 cycle itself.
  // A rise during that cycle therefore lands in the following cell.
  always_comb begin
    w_state_nx = r_state;
    w_ph_nx    = (r_ph == PH_LAST) ? '0 : r_ph + 1'b1;
    w_pf_nx    = (r_ph == PH_LAST) ? 1'b0 : r_pf;
    w_idle_nx  = r_idle;
    w_cell_end = 1'b0;

    if (w_rise) begin
      w_pf_nx = 1'b1;
      if (r_state == ST_UNLOCKED) begin
        // Hard align: treat this rise as the target phase.
        w_ph_nx    = PH_T + 1'b1;
        w_state_nx = ST_LOCKED;
        w_idle_nx  = '0;
      end else if ((r_ph != '0) && (r_ph < PH_PEN)) begin
        // At most one clk of correction per pulse; edges near the wrap are
        // left alone so the cell end is never skipped or repeated.
        if (r_ph < PH_T) begin
          w_ph_nx = r_ph + 2'd2;
        end else if (r_ph > PH_T) begin
          w_ph_nx = r_ph;
        end
      end
    end

    w_cell_end = (w_ph_nx == PH_LAST);

    if (w_cell_end) begin
      if (w_pf_nx) begin
        w_idle_nx = '0;
      end else if (r_idle != 4'hF) begin
        w_idle_nx = r_idle + 1'b1;
      end
      if (!w_pf_nx && (w_idle_nx >= IDLE_MAX)) begin
        w_state_nx = ST_UNLOCKED;
      end
    end

    // Disable overrides everything, including a coincident rise.
    if (!mir_rx_en) begin
      w_state_nx = ST_UNLOCKED;
      w_ph_nx    = '0;
      w_pf_nx    = 1'b0;
      w_idle_nx  = '0;
      w_cell_end = 1'b0;
    end
  end

  // Output process.
  always_comb begin
    rx_o             = r_rx;
    mir_rxbit_enable = r_stb;
    mir_dpll_locked  = (r_state == ST_LOCKED);
  end

endmodule

// File: tb/tb_irda_mir_rx_dpll.sv
// ---------------------------------------------------------------------------
// tb_irda_mir_rx_dpll
//
// Scoreboard bench for irda_mir_rx_dpll. The stimulus process steps a
// behavioural model of the bit-cell recovery rules every clock and queues the
// strobe it expects (cycle, bit, lock); a negedge monitor pops and compares
// whenever the DUT strobes, and flags strobes that are missing or spurious.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_irda_mir_rx_dpll;

  localparam int N    = 16;
  localparam int PHW  = 5;
  localparam int IDLE = 8;
  localparam int T    = N / 4;
`ifdef IRDA_MIR_RX_GLITCH_FILTER_EN
  localparam bit GLITCH = 1'b1;
`else
  localparam bit GLITCH = 1'b0;
`endif
  localparam int LAT = GLITCH ? 3 : 2;

  logic clk = 1'b0;
  logic wb_rst_i;
  logic rx_pad_i;
  logic mir_rx_en;
  logic rx_o;
  logic mir_rxbit_enable;
  logic mir_dpll_locked;

  always #5 clk = ~clk;

  irda_mir_rx_dpll #(
    .CLKS_PER_BIT(N),
    .PH_W        (PHW),
    .IDLE_CELLS  (IDLE)
  ) dut (
    .clk             (clk),
    .wb_rst_i        (wb_rst_i),
    .rx_pad_i        (rx_pad_i),
    .mir_rx_en       (mir_rx_en),
    .rx_o            (rx_o),
    .mir_rxbit_enable(mir_rxbit_enable),
    .mir_dpll_locked (mir_dpll_locked)
  );

  typedef struct {
    int unsigned cyc;
    bit          rx;
    bit          lk;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp   = 0;
  int unsigned n_err   = 0;
  int unsigned mon_cyc = 0;
  int unsigned m_cyc   = 0;

  // Reference model state
  int m_ph;
  int m_idle;
  bit m_pf;
  bit m_locked;
  bit m_s1, m_s, m_sd, m_sd2;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, mon_cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_idle = 0; m_pf = 1'b0; m_locked = 1'b0;
    m_s1 = 1'b0; m_s = 1'b0; m_sd = 1'b0; m_sd2 = 1'b0;
    sb.delete();
  endtask

  // One clock edge of the reference model, using the inputs the DUT sampled.
  task automatic model_step();
    bit rise;
    int nph;
    m_cyc++;
    if (wb_rst_i) begin
      model_reset();
      return;
    end
    rise = GLITCH ? (m_s && m_sd && !m_sd2) : (m_s && !m_sd);
    m_sd2 = m_sd; m_sd = m_s; m_s = m_s1; m_s1 = rx_pad_i;
    if (!mir_rx_en) begin
      m_ph = 0; m_pf = 1'b0; m_idle = 0; m_locked = 1'b0;
      return;
    end
    if (m_ph == N - 1) m_pf = 1'b0;   // previous cell already reported
    nph = (m_ph + 1) % N;
    if (rise) begin
      m_pf = 1'b1;
      if (!m_locked) begin
        nph = T + 1; m_locked = 1'b1; m_idle = 0;
      end else if (m_ph >= 1 && m_ph <= N - 3 && m_ph != T) begin
        nph = (m_ph < T) ? m_ph + 2 : m_ph;
      end
    end
    m_ph = nph;
    if (m_ph == N - 1) begin
      if (m_pf) m_idle = 0;
      else if (m_idle < 15) m_idle++;
      if (m_idle >= IDLE) m_locked = 1'b0;
      sb.push_back('{cyc: m_cyc, rx: !m_pf, lk: m_locked});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_ticks(input int n);
    rx_pad_i = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pulse(input int w, input int gap);
    rx_pad_i = 1'b1;
    repeat (w) tick();
    rx_pad_i = 1'b0;
    repeat (gap) tick();
  endtask

  // Idle until a pad edge driven now produces a rise at phase ph_target.
  task automatic aim(input int ph_target);
    int guard;
    guard = 0;
    rx_pad_i = 1'b0;
    while (m_ph != ((ph_target - LAT + N) % N) && guard < 4 * N) begin
      tick();
      guard++;
    end
    if (guard >= 4 * N) check("aim_timeout", guard, 0);
  endtask

  // Monitor / scoreboard
  always @(posedge clk) mon_cyc <= mon_cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    check("lock", int'(mir_dpll_locked), int'(m_locked));
    if (mir_rxbit_enable) begin
      if (sb.size() == 0) begin
        check("spurious_strobe", int'(mir_rxbit_enable), 0);
      end else begin
        e = sb.pop_front();
        check("strobe_cycle", int'(mon_cyc), int'(e.cyc));
        check("rx_o", int'(rx_o), int'(e.rx));
        check("strobe_lock", int'(mir_dpll_locked), int'(e.lk));
      end
    end else if (sb.size() != 0 && sb[0].cyc <= mon_cyc) begin
      check("missing_strobe", int'(mir_rxbit_enable), 1);
      void'(sb.pop_front());
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pat;
    int          off;
    bit          b;

    wb_rst_i  = 1'b1;
    rx_pad_i  = 1'b0;
    mir_rx_en = 1'b0;
    model_reset();
    repeat (3) tick();
    check("rst_rx_o", int'(rx_o), 1);
    check("rst_strobe", int'(mir_rxbit_enable), 0);
    check("rst_lock", int'(mir_dpll_locked), 0);

    // Idle pad with receive enabled: free-running strobes of idle ones.
    wb_rst_i  = 1'b0;
    mir_rx_en = 1'b1;
    idle_ticks(200);
    check("idle_unlocked", int'(mir_dpll_locked), 0);

    // Hard align on a rise at phase 9, then period-17 and period-15 trains.
    aim(9);
    pulse(4, 13);
    check("lock_acquired", int'(mir_dpll_locked), 1);
    repeat (16) pulse(4, 13);
    check("lock_hold_p17", int'(mir_dpll_locked), 1);
    repeat (16) pulse(4, 11);
    check("lock_hold_p15", int'(mir_dpll_locked), 1);

    // Pulse-free cells drop lock.
    idle_ticks(IDLE * N + N);
    check("lock_lost", int'(mir_dpll_locked), 0);

    // Flag 0x7E then 0xA5, LSB first, pulse = 0, with +-1 clk jitter.
    pat = {8'hA5, 8'h7E};
    for (int i = 0; i < 16; i++) begin
      b = pat[i];
      if (b) begin
        idle_ticks(N);
      end else begin
        off = T - LAT + int'($urandom_range(0, 2)) - 1;
        idle_ticks(off);
        pulse(4, N - off - 4);
      end
    end
    idle_ticks(2 * N);

    // Near-nominal jittered pulse train exercising both corrections.
    for (int i = 0; i < 100; i++) pulse(4, N - 4 + int'($urandom_range(0, 2)) - 1);

    // Random pulses, gaps and enable drops.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        mir_rx_en = 1'b0;
        repeat (int'($urandom_range(1, 4))) tick();
        mir_rx_en = 1'b1;
      end
      pulse(int'($urandom_range(1, 5)), int'($urandom_range(2, 30)));
    end

    // Single-clk pad pulse from a freshly enabled, unlocked state.
    mir_rx_en = 1'b0;
    idle_ticks(IDLE * N + 2);
    mir_rx_en = 1'b1;
    idle_ticks(5);
    pulse(1, 2 * N);
    check("single_clk_lock", int'(mir_dpll_locked), GLITCH ? 0 : 1);

    // Reset in the middle of a locked cell.
    repeat (3) pulse(4, 12);
    idle_ticks(7);
    wb_rst_i = 1'b1;
    model_reset();
    #1;
    check("midcell_rst_rx_o", int'(rx_o), 1);
    check("midcell_rst_strobe", int'(mir_rxbit_enable), 0);
    check("midcell_rst_lock", int'(mir_dpll_locked), 0);
    repeat (2) tick();
    wb_rst_i = 1'b0;
    idle_ticks(3 * N);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
